ps2_host_rx: RTL and testbench

- PS/2 host-side receiver. Deserialises the emulated keyboard/mouse PS/2 clock/data lines into bytes, checks framing and odd parity, and folds E0/F0 prefixes into a key event.
- Sits in the core between the I/O controller's PS/2 emulation outputs and the core's keyboard matrix or mouse logic.
- Runs entirely in the clk_sys domain. PS/2 lines are treated as asynchronous inputs.

---
 rtl/ps2_host_rx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: synchronise and filter clock/data, deframe 11-bit frames with odd parity and
// fold E0/F0 prefixes into key events. Define PS2_TIMEOUT_EN to abort stalled frames after TIMEOUT.
module ps2_host_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_t;

  localparam logic [7:0] FiltLast = 8'(FILTER_LEN - 1);

  logic       clk_s1, clk_s2, data_s1, data_s2;
  logic       filt_q, filt_prev_q;
  logic [7:0] flt_cnt_q;
  logic       fall;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       par_q, par_d;
  logic       ext_q, ext_d, rel_q, rel_d;
  logic [7:0] byte_d, key_code_d;
  logic       byte_stb_d, key_stb_d, key_ext_d, key_rel_d, err_d;
  logic       timeout_hit;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1      <= 1'b1;
      clk_s2      <= 1'b1;
      data_s1     <= 1'b1;
      data_s2     <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      clk_s1      <= ps2_clk;
      clk_s2      <= clk_s1;
      data_s1     <= ps2_data;
      data_s2     <= data_s1;
      filt_prev_q <= filt_q;
      // Any sample agreeing with the filtered level restarts the run count.
      if (clk_s2 != filt_q) begin
        if (flt_cnt_q == FiltLast) begin
          filt_q    <= clk_s2;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + 8'd1;
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;
  assign busy = (state_q != StIdle);

`ifdef PS2_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (fall || state_q == StIdle) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign timeout_hit = (state_q != StIdle) && (to_cnt_q == TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_d      = par_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    byte_d     = byte_out;
    byte_stb_d = 1'b0;
    key_code_d = key_code;
    key_ext_d  = key_ext;
    key_rel_d  = key_release;
    key_stb_d  = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!data_s2) begin
            state_d   = StData;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        StData: begin
          shift_d   = {data_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = data_s2;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (data_s2 && (^{shift_q, par_q})) begin
            byte_d     = shift_q;
            byte_stb_d = 1'b1;
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              rel_d = 1'b1;
            end else begin
              key_code_d = shift_q;
              key_ext_d  = ext_q;
              key_rel_d  = rel_q;
              key_stb_d  = 1'b1;
              ext_d      = 1'b0;
              rel_d      = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (timeout_hit) begin
      state_d = StIdle;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      byte_out    <= '0;
      byte_strobe <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_strobe  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      byte_out    <= byte_d;
      byte_strobe <= byte_stb_d;
      key_code    <= key_code_d;
      key_ext     <= key_ext_d;
      key_release <= key_rel_d;
      key_strobe  <= key_stb_d;
      frame_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: framing, parity, prefix folding, glitch rejection, reset and
// (with PS2_TIMEOUT_EN) the stalled-frame timeout.
module tb_ps2_host_rx;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_out, key_code;
  logic       byte_strobe, key_ext, key_release, key_strobe, frame_err, busy;

  int errors = 0;
  int checks = 0;
  int n_byte = 0, n_key = 0, n_err = 0, n_overlap = 0, n_busy = 0;
  int b0, k0, e0;

  ps2_host_rx #(
    .FILTER_LEN(8),
    .TIMEOUT   (16'd1000)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_out   (byte_out),
    .byte_strobe(byte_strobe),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_strobe (key_strobe),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Event counters sampled away from the active edge.
  always @(negedge clk_sys) begin
    if (byte_strobe) n_byte++;
    if (key_strobe) n_key++;
    if (frame_err) n_err++;
    if (busy) n_busy++;
    if ((key_strobe && !byte_strobe) || (byte_strobe && frame_err)) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // One PS/2 bit: data set mid-high, clock low for 100 cycles, 200-cycle period.
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(50);
    ps2_clk = 1'b0;
    cyc(100);
    ps2_clk = 1'b1;
    cyc(50);
  endtask

  task automatic send(input logic [7:0] d, input logic par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    cyc(100);
  endtask

  task automatic mark;
    b0 = n_byte;
    k0 = n_key;
    e0 = n_err;
  endtask

  initial begin
    cyc(3);
    check("reset_byte_out", 32'(byte_out), 32'h0);
    check("reset_key_code", 32'(key_code), 32'h0);
    check("reset_flags", 32'({byte_strobe, key_ext, key_release, key_strobe, frame_err, busy}), 32'h0);
    reset = 1'b0;
    cyc(20);

    // Plain make code
    mark();
    send(8'h1C, 1'b0);
    check("1c_byte_strobes", 32'(n_byte - b0), 32'd1);
    check("1c_byte_out", 32'(byte_out), 32'h1C);
    check("1c_key_strobes", 32'(n_key - k0), 32'd1);
    check("1c_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b0}));
    check("1c_no_err", 32'(n_err - e0), 32'd0);

    // Break code
    mark();
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b0);
    check("f0_1c_byte_strobes", 32'(n_byte - b0), 32'd2);
    check("f0_1c_key_strobes", 32'(n_key - k0), 32'd1);
    check("f0_1c_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b1}));

    // Extended break, then a plain key shows flags cleared
    mark();
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b0);
    check("e0f0_75_key_strobes", 32'(n_key - k0), 32'd1);
    check("e0f0_75_key", 32'({key_code, key_ext, key_release}), 32'({8'h75, 1'b1, 1'b1}));
    send(8'h1C, 1'b0);
    check("after_ext_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b0}));

    // Parity error after a prefix
    mark();
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    check("perr_err_count", 32'(n_err - e0), 32'd1);
    check("perr_no_key", 32'(n_key - k0), 32'd0);
    check("perr_byte_out", 32'(byte_out), 32'hF0);
    send(8'h1C, 1'b0);
    check("perr_then_good_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b0}));

    // Short clock glitch while idle
    mark();
    n_busy = 0;
    ps2_clk = 1'b0;
    cyc(3);
    ps2_clk = 1'b1;
    cyc(50);
    check("glitch_busy_cycles", 32'(n_busy), 32'd0);
    check("glitch_no_events", 32'((n_byte - b0) + (n_key - k0) + (n_err - e0)), 32'd0);

    // Reset mid-frame
    mark();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    check("partial_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    cyc(2);
    check("midreset_outputs", 32'({byte_out, key_code, byte_strobe, key_ext, key_release,
                                   key_strobe, frame_err, busy}), 32'h0);
    reset = 1'b0;
    cyc(300);
    check("midreset_busy_after", 32'(busy), 32'd0);
    check("midreset_no_events", 32'((n_byte - b0) + (n_key - k0) + (n_err - e0)), 32'd0);
    send(8'h1C, 1'b0);
    check("midreset_then_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b0}));
    check("midreset_then_key_strobes", 32'(n_key - k0), 32'd1);

`ifdef PS2_TIMEOUT_EN
    // Stalled frame: clock stops after the 5th data bit's falling edge
    begin
      int waited;
      mark();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b0);
      ps2_data = 1'b1;
      cyc(50);
      ps2_clk = 1'b0;
      waited = 0;
      // Filtered fall lands ~10 cycles after the line drops; error due ~1000 later.
      while (!frame_err && waited < 3000) begin
        cyc(1);
        waited++;
      end
      check("timeout_latency_ok", 32'(waited >= 1008 && waited <= 1014), 32'd1);
      cyc(2);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_err_count", 32'(n_err - e0), 32'd1);
      ps2_clk = 1'b1;
      cyc(100);
      send(8'h1C, 1'b0);
      check("timeout_then_key", 32'({key_code, key_ext, key_release}), 32'({8'h1C, 1'b0, 1'b0}));
    end
`endif

    check("strobe_overlap", 32'(n_overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
